// File: rtl/snow64_operand_forward_history_pkg.sv
// Purpose : shared defaults, entry layout and small helpers for the EX-stage operand forwarding unit.
// Latency : n/a (package only).
// Backpressure: n/a. The RTL carries entries as flat vectors so that non-default widths still elaborate.
package PkgSnow64OperandForward;

   localparam int DEF_DEPTH        = 3;
   localparam int DEF_NUM_RD_PORTS = 3;
   localparam int DEF_ADDR_WIDTH   = 59;
   localparam int DEF_DATA_WIDTH   = 256;
   localparam int DEF_BYPASS_CURR  = 0;
   localparam int DEF_NBYTES       = DEF_DATA_WIDTH / 8;

   // Entry layout at default widths. The history registers hold these same
   // fields, one flat vector per field.
   typedef struct packed {
      logic                      valid;
      logic [DEF_ADDR_WIDTH-1:0] base_addr;
      logic [DEF_DATA_WIDTH-1:0] data;
      logic [DEF_NBYTES-1:0]     byte_en;
   } FwdEntry;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int nbytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/snow64_operand_forward_history_merge.sv
// Purpose : byte-accurate merge for one LAR read port over all candidates (index 0 = youngest).
// Latency : purely combinational, 0 cycles.
// Backpressure: none; stall/flush are handled by whoever drives the candidate valids.
// Ports   : in_cand_* = flat candidate fields, in_rd_* = LAR file view,
//           out_rd_data = merged operand, out_rd_fwd_hit = any byte forwarded.
module snow64_operand_forward_merge
   import PkgSnow64OperandForward::*;
#(
   parameter int NUM_CAND   = DEF_DEPTH + 1,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
   input  logic [NUM_CAND-1:0]                in_cand_valid,
   input  logic [NUM_CAND*ADDR_WIDTH-1:0]     in_cand_base_addr,
   input  logic [NUM_CAND*DATA_WIDTH-1:0]     in_cand_data,
   input  logic [NUM_CAND*(DATA_WIDTH/8)-1:0] in_cand_byte_en,
   input  logic [ADDR_WIDTH-1:0]              in_rd_base_addr,
   input  logic [DATA_WIDTH-1:0]              in_rd_data,
   output logic [DATA_WIDTH-1:0]              out_rd_data,
   output logic                               out_rd_fwd_hit
);

   localparam int NB = nbytes(DATA_WIDTH);

   logic [NUM_CAND-1:0]   w_match;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_hit;

   always_comb begin
      w_match = '0;
      for (int c = 0; c < NUM_CAND; c++) begin
         w_match[c] = in_cand_valid[c] &&
                      (in_cand_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH] == in_rd_base_addr);
      end
   end

   // Walk oldest to youngest so a younger matching byte overwrites an older one;
   // bytes nobody wrote keep the LAR file value.
   always_comb begin
      w_data = in_rd_data;
      w_hit  = 1'b0;
      for (int c = NUM_CAND - 1; c >= 0; c--) begin
         if (w_match[c]) begin
            for (int b = 0; b < NB; b++) begin
               if (in_cand_byte_en[c*NB + b]) begin
                  w_data[b*8 +: 8] = in_cand_data[c*DATA_WIDTH + b*8 +: 8];
                  w_hit            = 1'b1;
               end
            end
         end
      end
   end

   assign out_rd_data    = w_data;
   assign out_rd_fwd_hit = w_hit;

endmodule

// File: rtl/snow64_operand_forward_history.sv
// Purpose : DEPTH-deep history of committed EX results forwarding bytes to NUM_RD_PORTS LAR read ports.
// Latency : reads 0 cycles (combinational); a write is visible the cycle after its edge (same cycle if BYPASS_CURR).
// Backpressure: in_stall freezes the history and drops the write; in_flush clears all entries and wins over stall.
// Ports   : clk/rst_n; in_stall/in_flush; in_wr_* EX result; in_rd_* flat per-port LAR view;
//           out_rd_data flat per-port operand, out_rd_fwd_hit per port, out_occupancy valid count.
module snow64_operand_forward_history
   import PkgSnow64OperandForward::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BYPASS_CURR  = DEF_BYPASS_CURR
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_stall,
   input  logic                               in_flush,
   input  logic                               in_wr_valid,
   input  logic [ADDR_WIDTH-1:0]              in_wr_base_addr,
   input  logic [DATA_WIDTH-1:0]              in_wr_data,
   input  logic [DATA_WIDTH/8-1:0]            in_wr_byte_en,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] in_rd_base_addr,
   input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] in_rd_data,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] out_rd_data,
   output logic [NUM_RD_PORTS-1:0]            out_rd_fwd_hit,
   output logic [$clog2(DEPTH+1)-1:0]         out_occupancy
);

   localparam int NB    = nbytes(DATA_WIDTH);
   localparam int OCC_W = occ_width(DEPTH);

   // History, entry 0 youngest, one flat vector per field.
   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH*ADDR_WIDTH-1:0] r_addr;
   logic [DEPTH*DATA_WIDTH-1:0] r_data;
   logic [DEPTH*NB-1:0]         r_byte_en;
   logic [OCC_W-1:0]            r_occ;

   logic [DEPTH-1:0]            w_valid_nxt;
   logic [DEPTH*ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DEPTH*DATA_WIDTH-1:0] w_data_nxt;
   logic [DEPTH*NB-1:0]         w_byte_en_nxt;
   logic [OCC_W-1:0]            w_occ_nxt;
   logic                        w_byp_vld;

   always_comb begin
      w_valid_nxt   = r_valid;
      w_addr_nxt    = r_addr;
      w_data_nxt    = r_data;
      w_byte_en_nxt = r_byte_en;
      if (in_flush) begin
         // Only the valids need clearing; stale payload can never match.
         w_valid_nxt = '0;
      end else if (!in_stall) begin
         for (int i = DEPTH - 1; i >= 1; i--) begin
            w_valid_nxt[i]                       = r_valid[i-1];
            w_addr_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
            w_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_data[(i-1)*DATA_WIDTH +: DATA_WIDTH];
            w_byte_en_nxt[i*NB +: NB]            = r_byte_en[(i-1)*NB +: NB];
         end
         // A write with no enabled bytes is stored as a bubble so it is not counted.
         w_valid_nxt[0]                = in_wr_valid && (|in_wr_byte_en);
         w_addr_nxt[0 +: ADDR_WIDTH]   = in_wr_base_addr;
         w_data_nxt[0 +: DATA_WIDTH]   = in_wr_data;
         w_byte_en_nxt[0 +: NB]        = in_wr_byte_en;
      end
   end

   always_comb begin
      w_occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_byte_en <= '0;
         r_occ     <= '0;
      end else begin
         r_valid   <= w_valid_nxt;
         r_addr    <= w_addr_nxt;
         r_data    <= w_data_nxt;
         r_byte_en <= w_byte_en_nxt;
         r_occ     <= w_occ_nxt;
      end
   end

   assign out_occupancy = r_occ;

   // Candidate 0 is the in-flight write (only live with bypass enabled and the
   // write actually committing); candidates 1..DEPTH are history entries 0..DEPTH-1.
   assign w_byp_vld = (BYPASS_CURR != 0) && in_wr_valid && !in_stall && !in_flush;

   logic [DEPTH:0]                w_cand_valid;
   logic [(DEPTH+1)*ADDR_WIDTH-1:0] w_cand_addr;
   logic [(DEPTH+1)*DATA_WIDTH-1:0] w_cand_data;
   logic [(DEPTH+1)*NB-1:0]       w_cand_byte_en;

   assign w_cand_valid   = {r_valid,   w_byp_vld};
   assign w_cand_addr    = {r_addr,    in_wr_base_addr};
   assign w_cand_data    = {r_data,    in_wr_data};
   assign w_cand_byte_en = {r_byte_en, in_wr_byte_en};

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      snow64_operand_forward_merge #(
         .NUM_CAND   (DEPTH + 1),
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_merge (
         .in_cand_valid     (w_cand_valid),
         .in_cand_base_addr (w_cand_addr),
         .in_cand_data      (w_cand_data),
         .in_cand_byte_en   (w_cand_byte_en),
         .in_rd_base_addr   (in_rd_base_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .in_rd_data        (in_rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .out_rd_data       (out_rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .out_rd_fwd_hit    (out_rd_fwd_hit[p])
      );
   end

endmodule

// File: tb/tb_snow64_operand_forward_history.sv
// Purpose : directed table plus hand sequences for the operand forwarding history, with and without bypass.
// Latency : checks sample 1ns after the falling edge, between rising edges.
// Backpressure: stall/flush/reset exercised in the hand sequences.
module tb_snow64_operand_forward_history;
   import PkgSnow64OperandForward::*;

   localparam int AW = 59;
   localparam int DW = 256;
   localparam int NB = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           st, fl;
   FwdEntry        wr;
   logic [AW-1:0]  ra0, ra1, ra2;
   logic [DW-1:0]  lar0, lar1, lar2;
   logic [3*DW-1:0] o0_data, o1_data;
   logic [2:0]     o0_hit, o1_hit;
   logic [1:0]     o0_occ, o1_occ;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   snow64_operand_forward_history #(.BYPASS_CURR(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_stall(st), .in_flush(fl),
      .in_wr_valid(wr.valid), .in_wr_base_addr(wr.base_addr),
      .in_wr_data(wr.data), .in_wr_byte_en(wr.byte_en),
      .in_rd_base_addr({ra2, ra1, ra0}), .in_rd_data({lar2, lar1, lar0}),
      .out_rd_data(o0_data), .out_rd_fwd_hit(o0_hit), .out_occupancy(o0_occ));

   snow64_operand_forward_history #(.BYPASS_CURR(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_stall(st), .in_flush(fl),
      .in_wr_valid(wr.valid), .in_wr_base_addr(wr.base_addr),
      .in_wr_data(wr.data), .in_wr_byte_en(wr.byte_en),
      .in_rd_base_addr({ra2, ra1, ra0}), .in_rd_data({lar2, lar1, lar0}),
      .out_rd_data(o1_data), .out_rd_fwd_hit(o1_hit), .out_occupancy(o1_occ));

   typedef struct {
      FwdEntry       w;
      logic [AW-1:0] a0, a1, a2;
      logic [DW-1:0] e0, e1;
      logic [2:0]    eh;
      logic [1:0]    eo;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      return {32{b}};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic add(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic [2:0] eh, input logic [1:0] eo);
      vec_t v;
      v.w.valid = wv; v.w.base_addr = wa; v.w.data = wd; v.w.byte_en = be;
      v.a0 = a0; v.a1 = a1; v.a2 = a2; v.e0 = e0; v.e1 = e1; v.eh = eh; v.eo = eo;
      vecs.push_back(v);
   endtask

   task automatic idle();
      wr = '0; st = 1'b0; fl = 1'b0;
   endtask

   task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr.valid = 1'b1; wr.base_addr = a; wr.data = d; wr.byte_en = '1;
   endtask

   logic [AW-1:0] hi_addr;
   logic [DW-1:0] part_old, part_lar;

   initial begin
      rst_n = 1'b0;
      idle();
      lar0 = rep(8'hAA); lar1 = rep(8'hBB); lar2 = rep(8'hCC);
      ra0 = 59'h10; ra1 = 59'h99; ra2 = 59'h98;
      hi_addr  = 59'h400000000000010;
      part_old = {{31{8'h22}}, 8'h33};
      part_lar = {{31{8'hAA}}, 8'h33};

      //  wv wa      wd          be        a0     a1       a2     e0          e1          hit    occ
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(1, 59'h10, rep(8'h11), '1,       59'h10, 59'h99,  59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'h11), rep(8'hBB), 3'b001, 2'd1);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'h11), rep(8'hBB), 3'b001, 2'd1);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'h11), rep(8'hBB), 3'b001, 2'd1);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(1, 59'h10, rep(8'h22), '1,       59'h10, 59'h99,  59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(1, 59'h10, rep(8'h33), 32'h1,    59'h10, 59'h99,  59'h98, rep(8'h22), rep(8'hBB), 3'b001, 2'd1);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h11,  59'h98, part_old,   rep(8'hBB), 3'b001, 2'd2);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h11,  59'h10, part_old,   rep(8'hBB), 3'b101, 2'd2);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, part_lar,   rep(8'hBB), 3'b001, 2'd1);
      add(0, 59'h0,  '0,         '0,       59'h10, 59'h99,  59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(1, hi_addr, rep(8'h44), '1,      59'h10, hi_addr, 59'h98, rep(8'hAA), rep(8'hBB), 3'b000, 2'd0);
      add(0, 59'h0,  '0,         '0,       59'h10, hi_addr, 59'h98, rep(8'hAA), rep(8'h44), 3'b010, 2'd1);

      // Reset state while rst_n is still low.
      #3;
      chk("rst_occ", DW'(o0_occ), '0);
      chk("rst_hit", DW'(o0_hit), '0);
      chk("rst_d0", o0_data[0 +: DW], rep(8'hAA));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         wr = vecs[i].w; st = 1'b0; fl = 1'b0;
         ra0 = vecs[i].a0; ra1 = vecs[i].a1; ra2 = vecs[i].a2;
         #1;
         chk($sformatf("v%0d_d0", i),  o0_data[0 +: DW],  vecs[i].e0);
         chk($sformatf("v%0d_d1", i),  o0_data[DW +: DW], vecs[i].e1);
         chk($sformatf("v%0d_hit", i), DW'(o0_hit),       DW'(vecs[i].eh));
         chk($sformatf("v%0d_occ", i), DW'(o0_occ),       DW'(vecs[i].eo));
         @(negedge clk);
      end

      // Stall: held write is ignored, existing entry keeps forwarding.
      idle();
      repeat (3) @(negedge clk);
      put(59'h20, rep(8'h66));
      @(negedge clk);
      ra0 = 59'h20; ra1 = 59'h30; ra2 = 59'h98;
      for (int k = 0; k < 5; k++) begin
         st = 1'b1; put(59'h30, rep(8'h77));
         #1;
         chk($sformatf("stall%0d_d0", k), o0_data[0 +: DW], rep(8'h66));
         chk($sformatf("stall%0d_hit0", k), DW'(o0_hit), DW'(3'b001));
         chk($sformatf("stall%0d_hit1", k), DW'(o1_hit), DW'(3'b001));
         chk($sformatf("stall%0d_occ", k), DW'(o0_occ), DW'(2'd1));
         @(negedge clk);
      end
      idle();
      #1;
      chk("stall_after_d0", o0_data[0 +: DW], rep(8'h66));
      chk("stall_after_d1", o0_data[DW +: DW], rep(8'hBB));

      // Flush with stall and a write present: everything invalid next cycle.
      repeat (3) @(negedge clk);
      put(59'h50, rep(8'h01)); @(negedge clk);
      put(59'h51, rep(8'h02)); @(negedge clk);
      put(59'h52, rep(8'h03)); @(negedge clk);
      ra0 = 59'h50; ra1 = 59'h51; ra2 = 59'h52;
      put(59'h50, rep(8'hFF)); st = 1'b1; fl = 1'b1;
      #1;
      chk("fill_occ", DW'(o0_occ), DW'(2'd3));
      chk("fill_hit", DW'(o0_hit), DW'(3'b111));
      chk("fill_d2", o0_data[2*DW +: DW], rep(8'h03));
      @(negedge clk);
      idle();
      #1;
      chk("flush_occ", DW'(o0_occ), '0);
      chk("flush_hit", DW'(o0_hit), '0);
      chk("flush_d0", o0_data[0 +: DW], rep(8'hAA));
      chk("flush_d2", o0_data[2*DW +: DW], rep(8'hCC));
      chk("flush_hit_byp", DW'(o1_hit), '0);

      // Asynchronous reset pulse between clock edges.
      @(negedge clk);
      put(59'h60, rep(8'h0F)); @(negedge clk);
      put(59'h61, rep(8'hF0)); @(negedge clk);
      idle(); ra0 = 59'h60; ra1 = 59'h61;
      #1;
      chk("prerst_occ", DW'(o0_occ), DW'(2'd2));
      chk("prerst_d1", o0_data[DW +: DW], rep(8'hF0));
      #1 rst_n = 1'b0;
      #1;
      chk("arst_occ", DW'(o0_occ), '0);
      chk("arst_hit", DW'(o0_hit), '0);
      chk("arst_d0", o0_data[0 +: DW], rep(8'hAA));
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("postrst_occ", DW'(o0_occ), '0);
      chk("postrst_d1", o0_data[DW +: DW], rep(8'hBB));

      // Same-cycle bypass only on the BYPASS_CURR=1 instance, and only when committing.
      @(negedge clk);
      ra0 = 59'h40; ra1 = 59'h99; ra2 = 59'h98;
      put(59'h40, rep(8'h55));
      #1;
      chk("byp_on_d0", o1_data[0 +: DW], rep(8'h55));
      chk("byp_on_hit", DW'(o1_hit), DW'(3'b001));
      chk("byp_off_d0", o0_data[0 +: DW], rep(8'hAA));
      chk("byp_off_hit", DW'(o0_hit), '0);
      st = 1'b1;
      #1;
      chk("byp_stall_d0", o1_data[0 +: DW], rep(8'hAA));
      st = 1'b0; fl = 1'b1;
      #1;
      chk("byp_flush_d0", o1_data[0 +: DW], rep(8'hAA));
      fl = 1'b0;
      @(negedge clk);
      idle();
      #1;
      chk("byp_hist0_d0", o0_data[0 +: DW], rep(8'h55));
      chk("byp_hist1_d0", o1_data[0 +: DW], rep(8'h55));
      chk("byp_hist_occ", DW'(o1_occ), DW'(2'd1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
